// File: rtl/i2c_temp_target_if.sv
// Open-drain I2C pin bundle for the ADT7420-style target: raw SCL/SDA levels in, SDA pull-down enable out.
interface i2c_temp_target_if;
  logic scl_in;
  logic sda_in;
  logic sda_oe;

  modport master (output scl_in, output sda_in, input sda_oe);
  modport slave  (input scl_in, input sda_in, output sda_oe);
endinterface

// File: rtl/i2c_temp_target.sv
// I2C target emulating an ADT7420: pointer write, repeated start, multi-byte temperature/ID reads.
// Define I2C_TARGET_WRITE_EN to accept data bytes after the pointer (register 0x03 writable).
module i2c_temp_target #(
  parameter logic [6:0] DEV_ADDR = 7'h48,
  parameter logic [7:0] ID_VALUE = 8'hCB
) (
  input  logic                FSM_Clk,
  input  logic                rst_n,
  i2c_temp_target_if.slave    bus,
  input  logic [15:0]         temp_value,
  output logic [7:0]          config_reg,
  output logic                busy,
  output logic                rd_done
);

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_ADDR      = 4'd1,
    ST_ADDR_ACK  = 4'd2,
    ST_PTR       = 4'd3,
    ST_PTR_ACK   = 4'd4,
    ST_WDATA     = 4'd5,
    ST_WDATA_ACK = 4'd6,
    ST_RDATA     = 4'd7,
    ST_RACK      = 4'd8,
    ST_WAIT_STOP = 4'd9
  } state_t;

  state_t      state_q, state_d;
  logic        scl_s1_q, scl_s2_q, scl_h_q, scl_s1_d, scl_s2_d, scl_h_d;
  logic        sda_s1_q, sda_s2_q, sda_h_q, sda_s1_d, sda_s2_d, sda_h_d;
  logic [7:0]  shift_q, shift_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  tx_q, tx_d;
  logic [3:0]  ptr_q, ptr_d;
  logic [7:0]  cfg_q, cfg_d;
  logic [15:0] shadow_q, shadow_d;
  logic        sda_oe_q, sda_oe_d;
  logic        busy_q, busy_d;
  logic        rd_done_q, rd_done_d;

  logic        scl_rise_s, scl_fall_s, start_s, stop_s;
  logic        byte_done_s, addr_match_s, rx_state_s;
  logic [7:0]  rd_byte_s;

  function automatic logic [7:0] reg_read(input logic [3:0] ptr, input logic [15:0] shadow,
                                          input logic [7:0] cfg);
    case (ptr)
      4'h0:    reg_read = shadow[15:8];
      4'h1:    reg_read = shadow[7:0];
      4'h3:    reg_read = cfg;
      4'hB:    reg_read = ID_VALUE;
      default: reg_read = 8'h00;
    endcase
  endfunction

  // Pin synchronizer chain: two metastability flops then one history flop per line
  always_comb begin
    scl_s1_d = bus.scl_in;
    scl_s2_d = scl_s1_q;
    scl_h_d  = scl_s2_q;
    sda_s1_d = bus.sda_in;
    sda_s2_d = sda_s1_q;
    sda_h_d  = sda_s2_q;
  end

  assign scl_rise_s   = scl_s2_q & ~scl_h_q;
  assign scl_fall_s   = ~scl_s2_q & scl_h_q;
  assign start_s      = scl_s2_q & scl_h_q & sda_h_q & ~sda_s2_q;
  assign stop_s       = scl_s2_q & scl_h_q & ~sda_h_q & sda_s2_q;
  assign byte_done_s  = scl_fall_s & (bit_cnt_q == 4'd8);
  assign addr_match_s = (shift_q[7:1] == DEV_ADDR);
  assign rx_state_s   = (state_q == ST_ADDR) || (state_q == ST_PTR) || (state_q == ST_WDATA);
  assign rd_byte_s    = reg_read(ptr_q, shadow_q, cfg_q);

  // State register and all datapath/output flops
  always_ff @(posedge FSM_Clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      scl_s1_q  <= 1'b1;
      scl_s2_q  <= 1'b1;
      scl_h_q   <= 1'b1;
      sda_s1_q  <= 1'b1;
      sda_s2_q  <= 1'b1;
      sda_h_q   <= 1'b1;
      shift_q   <= 8'h00;
      bit_cnt_q <= 4'd0;
      tx_q      <= 8'h00;
      ptr_q     <= 4'h0;
      cfg_q     <= 8'h00;
      shadow_q  <= 16'h0000;
      sda_oe_q  <= 1'b0;
      busy_q    <= 1'b0;
      rd_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      scl_s1_q  <= scl_s1_d;
      scl_s2_q  <= scl_s2_d;
      scl_h_q   <= scl_h_d;
      sda_s1_q  <= sda_s1_d;
      sda_s2_q  <= sda_s2_d;
      sda_h_q   <= sda_h_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      tx_q      <= tx_d;
      ptr_q     <= ptr_d;
      cfg_q     <= cfg_d;
      shadow_q  <= shadow_d;
      sda_oe_q  <= sda_oe_d;
      busy_q    <= busy_d;
      rd_done_q <= rd_done_d;
    end
  end

  // Next-state logic; bus START/STOP override any bit-level progress
  always_comb begin
    state_d = state_q;
    if (start_s) begin
      state_d = ST_ADDR;
    end else if (stop_s) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_IDLE;
        ST_ADDR: begin
          if (byte_done_s) state_d = addr_match_s ? ST_ADDR_ACK : ST_WAIT_STOP;
          else             state_d = ST_ADDR;
        end
        ST_ADDR_ACK: begin
          if (scl_fall_s) state_d = shift_q[0] ? ST_RDATA : ST_PTR;
          else            state_d = ST_ADDR_ACK;
        end
        ST_PTR: begin
          if (byte_done_s) state_d = ST_PTR_ACK;
          else             state_d = ST_PTR;
        end
        ST_PTR_ACK: begin
          if (scl_fall_s) begin
`ifdef I2C_TARGET_WRITE_EN
            state_d = ST_WDATA;
`else
            state_d = ST_WAIT_STOP;
`endif
          end else begin
            state_d = ST_PTR_ACK;
          end
        end
        ST_WDATA: begin
          if (byte_done_s) state_d = ST_WDATA_ACK;
          else             state_d = ST_WDATA;
        end
        ST_WDATA_ACK: begin
          if (scl_fall_s) state_d = ST_WDATA;
          else            state_d = ST_WDATA_ACK;
        end
        ST_RDATA: begin
          if (byte_done_s) state_d = ST_RACK;
          else             state_d = ST_RDATA;
        end
        ST_RACK: begin
          if (scl_rise_s && (bit_cnt_q == 4'd0) && sda_s2_q)      state_d = ST_WAIT_STOP;
          else if (scl_fall_s && (bit_cnt_q == 4'd1))             state_d = ST_RDATA;
          else                                                   state_d = ST_RACK;
        end
        ST_WAIT_STOP: state_d = ST_WAIT_STOP;
        default:      state_d = ST_IDLE;
      endcase
    end
  end

  // Outputs and datapath; sda_oe only moves on a detected SCL fall (or START/STOP)
  always_comb begin
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    tx_d      = tx_q;
    ptr_d     = ptr_q;
    cfg_d     = cfg_q;
    shadow_d  = shadow_q;
    sda_oe_d  = sda_oe_q;
    rd_done_d = 1'b0;
    busy_d    = (state_d == ST_ADDR_ACK) || (state_d == ST_PTR)   || (state_d == ST_PTR_ACK) ||
                (state_d == ST_WDATA)    || (state_d == ST_WDATA_ACK) ||
                (state_d == ST_RDATA)    || (state_d == ST_RACK);
    if (start_s || stop_s) begin
      sda_oe_d  = 1'b0;
      bit_cnt_d = 4'd0;
    end else begin
      if (rx_state_s && scl_rise_s && (bit_cnt_q != 4'd8)) begin
        shift_d   = {shift_q[6:0], sda_s2_q};
        bit_cnt_d = bit_cnt_q + 4'd1;
      end else begin
        shift_d   = shift_q;
      end
      case (state_q)
        ST_ADDR: begin
          if (byte_done_s) begin
            bit_cnt_d = 4'd0;
            sda_oe_d  = addr_match_s;
            // One snapshot per read keeps MSB/LSB from tearing
            if (addr_match_s && shift_q[0]) shadow_d = temp_value;
            else                            shadow_d = shadow_q;
          end else begin
            sda_oe_d = 1'b0;
          end
        end
        ST_ADDR_ACK: begin
          if (scl_fall_s) begin
            if (shift_q[0]) begin
              tx_d      = rd_byte_s;
              sda_oe_d  = ~rd_byte_s[7];
              bit_cnt_d = 4'd1;
            end else begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = 4'd0;
            end
          end else begin
            sda_oe_d = 1'b1;
          end
        end
        ST_PTR: begin
          if (byte_done_s) begin
            bit_cnt_d = 4'd0;
            ptr_d     = shift_q[3:0];
            sda_oe_d  = 1'b1;
          end else begin
            sda_oe_d  = 1'b0;
          end
        end
        ST_WDATA: begin
          if (byte_done_s) begin
            bit_cnt_d = 4'd0;
            sda_oe_d  = 1'b1;
            ptr_d     = ptr_q + 4'd1;
`ifdef I2C_TARGET_WRITE_EN
            if (ptr_q == 4'h3) cfg_d = shift_q;
            else               cfg_d = cfg_q;
`endif
          end else begin
            sda_oe_d  = 1'b0;
          end
        end
        ST_PTR_ACK, ST_WDATA_ACK: begin
          if (scl_fall_s) begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = 4'd0;
          end else begin
            sda_oe_d  = 1'b1;
          end
        end
        ST_RDATA: begin
          if (scl_fall_s) begin
            if (bit_cnt_q == 4'd8) begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = 4'd0;
            end else begin
              tx_d      = {tx_q[6:0], 1'b0};
              sda_oe_d  = ~tx_q[6];
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end else begin
            sda_oe_d = sda_oe_q;
          end
        end
        ST_RACK: begin
          // bit_cnt 0: waiting for master's ACK bit; 1: ACK seen, reload on next fall
          if (scl_rise_s && (bit_cnt_q == 4'd0)) begin
            rd_done_d = 1'b1;
            if (!sda_s2_q) begin
              ptr_d     = ptr_q + 4'd1;
              bit_cnt_d = 4'd1;
            end else begin
              bit_cnt_d = 4'd0;
            end
          end else if (scl_fall_s && (bit_cnt_q == 4'd1)) begin
            tx_d     = rd_byte_s;
            sda_oe_d = ~rd_byte_s[7];
          end else begin
            sda_oe_d = 1'b0;
          end
        end
        ST_IDLE, ST_WAIT_STOP: begin
          sda_oe_d  = 1'b0;
          bit_cnt_d = 4'd0;
        end
        default: begin
          sda_oe_d  = 1'b0;
          bit_cnt_d = 4'd0;
        end
      endcase
    end
  end

  assign bus.sda_oe = sda_oe_q;
  assign config_reg = cfg_q;
  assign busy       = busy_q;
  assign rd_done    = rd_done_q;

endmodule

// File: tb/tb_i2c_temp_target.sv
// Bench for i2c_temp_target: bit-banged I2C master, transaction-level register model, per-cycle compare.
module tb_i2c_temp_target;
  localparam int H = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        scl_m, sda_m;
  logic [15:0] temp_value;
  logic [7:0]  config_reg;
  logic        busy, rd_done;

  always #5 clk = ~clk;

  i2c_temp_target_if bus();
  assign bus.scl_in = scl_m;
  assign bus.sda_in = sda_m & ~bus.sda_oe;

  i2c_temp_target dut (
    .FSM_Clk(clk), .rst_n(rst_n), .bus(bus), .temp_value(temp_value),
    .config_reg(config_reg), .busy(busy), .rd_done(rd_done)
  );

  int checks = 0;
  int failures = 0;

  logic [3:0]  m_ptr;
  logic [7:0]  m_cfg;
  logic [15:0] m_shadow;
  logic        m_match;
  int          m_wr_idx;
  logic        exp_oe, m_busy, chk_en;
  int          exp_rd;
  int          rd_cnt = 0;
  int          busy_cnt = 0;
  int          hi_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic logic [7:0] reg_model(input logic [3:0] p);
    case (p)
      4'h0:    return m_shadow[15:8];
      4'h1:    return m_shadow[7:0];
      4'h3:    return m_cfg;
      4'hB:    return 8'hCB;
      default: return 8'h00;
    endcase
  endfunction

  always @(posedge clk) begin
    hi_cnt <= scl_m ? hi_cnt + 1 : 0;
    if (rd_done === 1'b1) rd_cnt <= rd_cnt + 1;
    if (busy === 1'b1) busy_cnt <= busy_cnt + 1;
  end

  // Outputs are meaningful once SCL has been high long enough for the sync chain
  always @(negedge clk) begin
    if (chk_en && scl_m && hi_cnt >= 6) begin
      chk("sda_oe", bus.sda_oe, exp_oe);
      chk("busy", busy, m_busy);
      chk("config_reg", config_reg, m_cfg);
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_bit(input logic drv, input logic eoe, input logic eb, output logic seen);
    sda_m = drv; exp_oe = eoe; m_busy = eb;
    wait_cyc(H);
    scl_m = 1'b1;
    wait_cyc(H);
    seen = bus.sda_in;
    scl_m = 1'b0;
  endtask

  task automatic i2c_start();
    chk_en = 1'b0;
    sda_m = 1'b1; wait_cyc(H);
    scl_m = 1'b1; wait_cyc(H);
    sda_m = 1'b0; wait_cyc(H);
    scl_m = 1'b0;
    m_busy = 1'b0; exp_oe = 1'b0; m_wr_idx = 0; m_match = 1'b0;
    chk_en = 1'b1;
  endtask

  task automatic i2c_stop();
    chk_en = 1'b0;
    sda_m = 1'b0; wait_cyc(H);
    scl_m = 1'b1; wait_cyc(H);
    sda_m = 1'b1; wait_cyc(H);
    m_busy = 1'b0; exp_oe = 1'b0; m_match = 1'b0;
    chk_en = 1'b1;
  endtask

  task automatic xfer_addr(input logic [7:0] b, output logic ack);
    logic s;
    logic match;
    match = (b[7:1] == 7'h48);
    for (int i = 7; i >= 0; i--) do_bit(b[i], 1'b0, 1'b0, s);
    m_match = match;
    if (match && b[0]) m_shadow = temp_value;
    do_bit(1'b1, match, match, s);
    ack = ~s;
  endtask

  task automatic xfer_wr(input logic [7:0] b, output logic ack);
    logic s;
    logic take;
    if (m_wr_idx == 0) take = m_match;
    else begin
`ifdef I2C_TARGET_WRITE_EN
      take = m_match;
`else
      take = 1'b0;
`endif
    end
    for (int i = 7; i >= 0; i--) do_bit(b[i], 1'b0, take, s);
    if (take) begin
      if (m_wr_idx == 0) m_ptr = b[3:0];
      else begin
        if (m_ptr == 4'h3) m_cfg = b;
        m_ptr = m_ptr + 4'd1;
      end
    end
    do_bit(1'b1, take, take, s);
    ack = ~s;
    if (!take) m_match = 1'b0;
    m_wr_idx++;
  endtask

  task automatic xfer_rd(input logic mack, output logic [7:0] got);
    logic s;
    logic [7:0] e;
    e = reg_model(m_ptr);
    for (int i = 7; i >= 0; i--) begin
      do_bit(1'b1, ~e[i], 1'b1, s);
      got[i] = s;
    end
    do_bit(mack, 1'b0, ~mack, s);
    exp_rd++;
    if (!mack) m_ptr = m_ptr + 4'd1;
    else m_match = 1'b0;
    chk("rd_byte", got, e);
  endtask

  initial begin
    logic a;
    logic [7:0] g;
    logic [7:0] exp_cfg;
    logic exp_wack;
    int rd0, bz0, n;
    logic [6:0] addr;

    rst_n = 1'b0; scl_m = 1'b1; sda_m = 1'b1; temp_value = 16'h0000;
    chk_en = 1'b0; exp_oe = 1'b0; m_busy = 1'b0; exp_rd = 0;
    m_ptr = 4'h0; m_cfg = 8'h00; m_shadow = 16'h0000; m_match = 1'b0; m_wr_idx = 0;
    wait_cyc(5);
    chk("rst_sda_oe", bus.sda_oe, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rd_done", rd_done, 1'b0);
    chk("rst_config", config_reg, 8'h00);
    rst_n = 1'b1;
    wait_cyc(4);
    chk_en = 1'b1;

    // Pointer write, repeated start, two-byte read
    temp_value = 16'h0C80;
    rd0 = rd_cnt;
    i2c_start(); xfer_addr(8'h90, a); chk("t1_addr_w_ack", a, 1'b1);
    xfer_wr(8'h00, a); chk("t1_ptr_ack", a, 1'b1);
    i2c_start(); xfer_addr(8'h91, a); chk("t1_addr_r_ack", a, 1'b1);
    xfer_rd(1'b0, g); chk("t1_msb", g, 8'h0C);
    xfer_rd(1'b1, g); chk("t1_lsb", g, 8'h80);
    i2c_stop(); wait_cyc(4);
    chk("t1_rd_done_pulses", rd_cnt - rd0, 2);
    chk("t1_busy_after_stop", busy, 1'b0);

    // Foreign address: never ACKed, never busy
    bz0 = busy_cnt;
    i2c_start(); xfer_addr(8'h92, a); chk("t2_nack", a, 1'b0);
    xfer_wr(8'h00, a);
    i2c_stop();
    chk("t2_busy_never", busy_cnt - bz0, 0);

    // ID register and pointer wrap
    i2c_start(); xfer_addr(8'h90, a); xfer_wr(8'h0B, a);
    i2c_start(); xfer_addr(8'h91, a); xfer_rd(1'b1, g); chk("t3_id", g, 8'hCB);
    i2c_stop();
    i2c_start(); xfer_addr(8'h90, a); xfer_wr(8'h0F, a);
    i2c_start(); xfer_addr(8'h91, a);
    xfer_rd(1'b0, g); chk("t3_reg_f", g, 8'h00);
    xfer_rd(1'b1, g); chk("t3_wrap_msb", g, 8'h0C);
    i2c_stop();

    // Config register write
`ifdef I2C_TARGET_WRITE_EN
    exp_wack = 1'b1; exp_cfg = 8'hA0;
`else
    exp_wack = 1'b0; exp_cfg = 8'h00;
`endif
    i2c_start(); xfer_addr(8'h90, a); xfer_wr(8'h03, a); xfer_wr(8'hA0, a);
    chk("t4_data_ack", a, exp_wack);
    i2c_stop(); wait_cyc(4);
    chk("t4_config", config_reg, exp_cfg);

    // temp_value changes mid-read must not tear
    i2c_start(); xfer_addr(8'h90, a); xfer_wr(8'h00, a);
    i2c_start(); xfer_addr(8'h91, a);
    xfer_rd(1'b0, g); chk("t5_msb", g, 8'h0C);
    temp_value = 16'h1900;
    xfer_rd(1'b1, g); chk("t5_lsb", g, 8'h80);
    i2c_stop();

    // Reset while the target is pulling SDA low in a read bit
    temp_value = 16'h0C80;
    i2c_start(); xfer_addr(8'h90, a); xfer_wr(8'h00, a);
    i2c_start(); xfer_addr(8'h91, a);
    chk_en = 1'b0;
    wait_cyc(5);
    chk("t6_pre_oe", bus.sda_oe, 1'b1);
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); #1;
    chk("t6_oe_released", bus.sda_oe, 1'b0);
    chk("t6_busy", busy, 1'b0);
    chk("t6_config", config_reg, 8'h00);
    rst_n = 1'b1;
    m_cfg = 8'h00; m_ptr = 4'h0; m_shadow = 16'h0000; m_match = 1'b0;
    i2c_stop();

    // Randomized transactions against the model
    for (int it = 0; it < 30; it++) begin
      temp_value = 16'($urandom);
      addr = ($urandom_range(0, 7) == 0) ? 7'h49 : 7'h48;
      i2c_start(); xfer_addr({addr, 1'b0}, a);
      xfer_wr({4'($urandom_range(0, 15)), 4'($urandom_range(0, 15))}, a);
      if ($urandom_range(0, 1) == 1) xfer_wr(8'($urandom), a);
      if (m_match) begin
        rd0 = rd_cnt;
        i2c_start(); xfer_addr({addr, 1'b1}, a);
        n = $urandom_range(1, 3);
        for (int k = 0; k < n; k++) begin
          if (k == 1) temp_value = 16'($urandom);
          xfer_rd((k == n - 1) ? 1'b1 : 1'b0, g);
        end
        i2c_stop(); wait_cyc(4);
        chk("rnd_rd_done", rd_cnt - rd0, n);
      end else begin
        i2c_stop();
      end
      wait_cyc($urandom_range(2, 12));
    end

    chk("total_rd_done", rd_cnt, exp_rd);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
